seg7_mux_ctrl: RTL and testbench

SEG7_MUX_CTRL -- requirements
Module: seg7_mux_ctrl

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_char_rom.sv | 38 +++
 rtl/seg7_mux_ctrl.sv | 123 ++++++++++++
 tb/tb_seg7_mux_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment multiplexer: character codes,
// active-low glyphs ({a,b,c,d,e,f,g,dp}) and the blank pattern.
package seg7_pkg;

  // Character codes beyond the hex range
  localparam logic [4:0] CH_N     = 5'h10;
  localparam logic [4:0] CH_P     = 5'h11;
  localparam logic [4:0] CH_DASH  = 5'h12;
  localparam logic [4:0] CH_L     = 5'h13;
  localparam logic [4:0] CH_H     = 5'h14;
  localparam logic [4:0] CH_BLANK = 5'h1F;

  // Active-low glyphs; bit 0 (dp) is always 1 (off)
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_A     = 8'h11;
  localparam logic [7:0] SEG_B     = 8'hC1;
  localparam logic [7:0] SEG_C     = 8'h63;
  localparam logic [7:0] SEG_D     = 8'h85;
  localparam logic [7:0] SEG_E     = 8'h61;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_N     = 8'h13;
  localparam logic [7:0] SEG_P     = 8'h31;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_L     = 8'hE3;
  localparam logic [7:0] SEG_H     = 8'h91;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_char_rom.sv
// Combinational character decoder: 5-bit code to active-low segment pattern.
module seg7_char_rom
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] seg
);

  // Code lookup; unused codes decode to blank
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'h00:   seg = SEG_0;
      5'h01:   seg = SEG_1;
      5'h02:   seg = SEG_2;
      5'h03:   seg = SEG_3;
      5'h04:   seg = SEG_4;
      5'h05:   seg = SEG_5;
      5'h06:   seg = SEG_6;
      5'h07:   seg = SEG_7;
      5'h08:   seg = SEG_8;
      5'h09:   seg = SEG_9;
      5'h0A:   seg = SEG_A;
      5'h0B:   seg = SEG_B;
      5'h0C:   seg = SEG_C;
      5'h0D:   seg = SEG_D;
      5'h0E:   seg = SEG_E;
      5'h0F:   seg = SEG_F;
      CH_N:    seg = SEG_N;
      CH_P:    seg = SEG_P;
      CH_DASH: seg = SEG_DASH;
      CH_L:    seg = SEG_L;
      CH_H:    seg = SEG_H;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_mux_ctrl.sv
// Multiplexed seven-segment display controller with frame-synchronous
// double buffering and anti-ghost blanking at the start of every slot.
// Optional blinking of selected digits is enabled with macro SEG7_BLINK_EN.
//
// Load handshake: load is a single-cycle strobe that captures chars into a
// shadow buffer and marks it pending; the pending shadow moves to the
// displayed buffer only on the last cycle of a scan frame, and load_ack is
// high for exactly the one cycle in which the new content becomes active.
module seg7_mux_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 50_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                    clk_50MHz,
  input  logic                    reset_button,
  input  logic [5*NUM_DIGITS-1:0] chars,
  input  logic                    load,
  output logic                    load_ack,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit
);

  localparam int TICK = CLK_HZ / REFRESH_HZ;
  localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int SW   = $clog2(NUM_DIGITS);

  logic [TW-1:0]           timer;
  logic [SW-1:0]           sel;
  logic [5*NUM_DIGITS-1:0] shadow;
  logic [5*NUM_DIGITS-1:0] active;
  logic                    pending;
  logic                    slot_end;
  logic                    frame_end;
  logic [4:0]              cur_code;
  logic [7:0]              rom_seg;
  logic                    show_blank;

  assign slot_end  = (timer == TW'(TICK - 1));
  assign frame_end = slot_end && (sel == SW'(NUM_DIGITS - 1));
  assign cur_code  = active[5*int'(sel) +: 5];

  seg7_char_rom u_rom (
    .code (cur_code),
    .seg  (rom_seg)
  );

  // Slot timer and digit select counter
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      timer <= '0;
      sel   <= '0;
    end else if (slot_end) begin
      timer <= '0;
      sel   <= (sel == SW'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Shadow capture and frame-boundary transfer to the displayed buffer
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      shadow   <= {NUM_DIGITS{CH_BLANK}};
      active   <= {NUM_DIGITS{CH_BLANK}};
      pending  <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= frame_end && pending;
      if (frame_end && pending) active <= shadow;
      // A load on the boundary itself re-arms pending for the next frame
      if (load) begin
        shadow  <= chars;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] frame_cnt;
  logic          blink_off;

  // Frame counter toggling the blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign show_blank = blink_off && blink_mask[sel];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign show_blank   = 1'b0;
`endif

  // Registered segment and digit drive, one clock behind the select counter
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      seg   <= SEG_BLANK;
      digit <= '0;
    end else begin
      seg   <= show_blank ? SEG_BLANK : rom_seg;
      digit <= (timer < TW'(BLANK_CYCLES)) ? '0 : (NUM_DIGITS'(1) << sel);
    end
  end

endmodule

// File: tb/tb_seg7_mux_ctrl.sv
// Self-checking bench for seg7_mux_ctrl with a frame-level reference model.
module tb_seg7_mux_ctrl;

  localparam int N       = 4;
  localparam int CLK_HZ  = 1000;
  localparam int REF_HZ  = 100;
  localparam int TICK    = CLK_HZ / REF_HZ;
  localparam int BLANK   = 2;
  localparam int BLINK   = 2;
  localparam int FR      = N * TICK;
  localparam int W       = 5 * N;

  logic          clk_50MHz = 1'b0;
  logic          reset_button = 1'b1;
  logic [W-1:0]  chars = '0;
  logic          load = 1'b0;
  logic          load_ack;
  logic [N-1:0]  blink_mask = '0;
  logic [7:0]    seg;
  logic [N-1:0]  digit;

  seg7_mux_ctrl #(
    .NUM_DIGITS   (N),
    .CLK_HZ       (CLK_HZ),
    .REFRESH_HZ   (REF_HZ),
    .BLANK_CYCLES (BLANK),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .chars        (chars),
    .load         (load),
    .load_ack     (load_ack),
    .blink_mask   (blink_mask),
    .seg          (seg),
    .digit        (digit)
  );

  // Clock and reset-relative cycle counter (k = rising edges since release)
  always #5 clk_50MHz = ~clk_50MHz;

  int k;
  always @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) k <= 0;
    else              k <= k + 1;
  end

  int tests = 0;
  int fails = 0;

  // Scoreboard: expected ack cycle and the chars that become displayed then
  logic [31:0]  exp_q[$];
  logic [W-1:0] exp_chars_q[$];
  logic [W-1:0] model_active = {N{5'h1F}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, req);
    end
  endtask

  // Glyph built from the list of lit segments (a..g), active-low, dp off
  function automatic logic [7:0] glyph(input logic [4:0] code);
    string lit;
    logic [7:0] r;
    case (code)
      5'h00: lit = "abcdef";  5'h01: lit = "bc";      5'h02: lit = "abdeg";
      5'h03: lit = "abcdg";   5'h04: lit = "bcfg";    5'h05: lit = "acdfg";
      5'h06: lit = "acdefg";  5'h07: lit = "abc";     5'h08: lit = "abcdefg";
      5'h09: lit = "abcdfg";  5'h0A: lit = "abcefg";  5'h0B: lit = "cdefg";
      5'h0C: lit = "adef";    5'h0D: lit = "bcdeg";   5'h0E: lit = "adefg";
      5'h0F: lit = "aefg";    5'h10: lit = "abcef";   5'h11: lit = "abefg";
      5'h12: lit = "g";       5'h13: lit = "def";     5'h14: lit = "bcefg";
      default: lit = "";
    endcase
    r = 8'hFF;
    for (int i = 0; i < lit.len(); i++) r[7 - (int'(lit[i]) - 97)] = 1'b0;
    return r;
  endfunction

  // Monitor: outputs seen after edge k reflect scan position s = k-1
  always @(negedge clk_50MHz) begin
    int s, sl, sel_i;
    logic [7:0]  exp_seg;
    logic [N-1:0] exp_digit;
    logic [31:0] t;
    logic [W-1:0] c;
    logic ack_due;
    if (reset_button) begin
      check("reset_seg", seg, 8'hFF);
      check("reset_digit", digit, 0);
      check("reset_ack", load_ack, 0);
    end else if (k >= 1) begin
      s     = k - 1;
      sl    = s % TICK;
      sel_i = (s / TICK) % N;
      exp_digit = (sl < BLANK) ? '0 : N'(1 << sel_i);
      exp_seg   = glyph(model_active[5*sel_i +: 5]);
`ifdef SEG7_BLINK_EN
      if (blink_mask[sel_i] && (((s / FR) / BLINK) % 2 == 1)) exp_seg = 8'hFF;
`endif
      check("digit", digit, exp_digit);
      check("seg", seg, exp_seg);
      ack_due = (exp_q.size() > 0) && (exp_q[0] == 32'(k));
      if (load_ack || ack_due) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", load_ack, 0);
        end else begin
          t = exp_q.pop_front();
          c = exp_chars_q.pop_front();
          check("ack_time", k, t);
          check("ack_seen", load_ack, 1);
          model_active = c;
        end
      end
    end
  end

  // Expected effect of a load issued while the scan is at position s
  task automatic schedule(input int s, input logic [W-1:0] c);
    int f, tgt;
    f   = s / FR;
    tgt = ((s % FR) == FR - 1) ? (f + 2) * FR : (f + 1) * FR;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1] == 32'(tgt))
      exp_chars_q[exp_chars_q.size()-1] = c;
    else begin
      exp_q.push_back(32'(tgt));
      exp_chars_q.push_back(c);
    end
  endtask

  task automatic load_at(input int s, input logic [W-1:0] c);
    @(negedge clk_50MHz);
    while (k < s) @(negedge clk_50MHz);
    chars = c;
    load  = 1'b1;
    schedule(k, c);
    @(negedge clk_50MHz);
    load  = 1'b0;
  endtask

  task automatic do_reset(input logic [N-1:0] mask, input int hold);
    @(negedge clk_50MHz);
    #2;
    reset_button = 1'b1;
    load = 1'b0;
    exp_q.delete();
    exp_chars_q.delete();
    model_active = {N{5'h1F}};
    blink_mask = mask;
    repeat (hold) @(negedge clk_50MHz);
    #2;
    reset_button = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_chars(input int maxcode);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[5*i +: 5] = 5'($urandom_range(0, maxcode));
    return r;
  endfunction

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  initial begin
    int s;
    do_reset(N'($urandom_range(0, (1 << N) - 1)), 3);
    run_cycles(FR);
    // "OPEN" loaded mid-frame
    load_at(55, {5'h00, 5'h11, 5'h0E, 5'h10});
    // Two loads inside one frame, only the second is shown
    load_at(95, rand_chars(31));
    load_at(100, rand_chars(31));
    // Load on a boundary with nothing pending, then on a boundary with pending
    load_at(4 * FR - 1, rand_chars(20));
    load_at(5 * FR - 1, rand_chars(20));
    // Random loads at random scan positions
    for (int i = 0; i < 20; i++) begin
      s = k + $urandom_range(2, 60);
      load_at(s, rand_chars(31));
    end
    run_cycles(3 * FR);
    // Reset shortly after a load drops the pending content
    s = (k / FR + 1) * FR + 5;
    load_at(s, rand_chars(15));
    run_cycles(2);
    do_reset(N'($urandom_range(0, (1 << N) - 1)), 2);
    run_cycles(2 * FR);
    // Blink on digit 0 only
    do_reset(N'(1), 2);
    load_at(10, rand_chars(15));
    run_cycles(8 * FR);
    // Drain remaining expectations within a bounded window
    for (int i = 0; i < 3 * FR && exp_q.size() > 0; i++) @(negedge clk_50MHz);
    check("drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
